// File: rtl/sram_pack_writer.sv
// Packs a stream of DATA_W-bit words into PACK_N-word SRAM lines and writes each
// completed (or flushed) line at consecutive addresses from base_addr, stopping after DEPTH lines.
module sram_pack_writer #(
  parameter int DATA_W    = 32,
  parameter int PACK_N    = 3,
  parameter int ADDR_W    = 19,
  parameter int DEPTH     = 2**19,
  parameter int MSB_FIRST = 1
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       enable,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [PACK_N*DATA_W-1:0]   wr_data,
  input  logic                       wr_ready,
  output logic [ADDR_W:0]            line_cnt,
  output logic                       done
);

  localparam int                SLOT_W    = $clog2(PACK_N);
  localparam int                LINE_W    = PACK_N * DATA_W;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PACK_N - 1);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q,  slot_d;
  logic [LINE_W-1:0]   line_q,  line_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [ADDR_W:0]     cnt_q,   cnt_d;
  logic                accept;

  // NOTE: every variable gets its hold value first so no path through the case leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    line_d  = line_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    accept  = (state_q == ST_FILL) && in_valid;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FILL;
        addr_d  = base_addr;
      end
      ST_FILL: begin
        if (accept) begin
          for (int i = 0; i < PACK_N; i++) begin
            if (slot_q == SLOT_W'(i)) begin
              line_d[((MSB_FIRST != 0) ? (PACK_N - 1 - i) : i) * DATA_W +: DATA_W] = in_data;
            end
          end
          // A flush alongside an accept closes the line after storing this word.
          if (slot_q == LAST_SLOT || flush) begin
            state_d = ST_WRITE;
            slot_d  = '0;
          end else begin
            slot_d  = slot_q + 1'b1;
          end
        end else if (flush && slot_q != '0) begin
          state_d = ST_WRITE;
          slot_d  = '0;
        end
      end
      ST_WRITE: begin
        if (wr_ready) begin
          line_d  = '0;
          cnt_d   = cnt_q + 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = (cnt_q + 1'b1 == DEPTH_C) ? ST_DONE : ST_FILL;
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase

    // Dropping enable wins over everything, including a write still waiting on wr_ready.
    if (!enable) begin
      state_d = ST_IDLE;
      slot_d  = '0;
      line_d  = '0;
      cnt_d   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the
  // same pre-edge values; the line register is a plain register, so resetting it is cheap.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready = (state_q == ST_FILL);
  assign wr_en    = (state_q == ST_WRITE);
  assign done     = (state_q == ST_DONE);
  assign wr_addr  = addr_q;
  assign wr_data  = line_q;
  assign line_cnt = cnt_q;

endmodule

// File: tb/tb_sram_pack_writer.sv
// Directed bench for sram_pack_writer: default build (a_), DEPTH=4 wrap build (b_),
// and LSB-first PACK_N=4 build (c_), driven on negedges and checked on negedges.
module tb_sram_pack_writer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Instance a: defaults
  logic        a_enable, a_in_valid, a_flush, a_wr_ready;
  logic [18:0] a_base;
  logic [31:0] a_in_data;
  logic        a_in_ready, a_wr_en, a_done;
  logic [18:0] a_wr_addr;
  logic [95:0] a_wr_data;
  logic [19:0] a_line_cnt;

  // Instance b: DEPTH=4
  logic        b_enable, b_in_valid, b_flush, b_wr_ready;
  logic [18:0] b_base;
  logic [31:0] b_in_data;
  logic        b_in_ready, b_wr_en, b_done;
  logic [18:0] b_wr_addr;
  logic [95:0] b_wr_data;
  logic [19:0] b_line_cnt;

  // Instance c: MSB_FIRST=0, PACK_N=4
  logic         c_enable, c_in_valid, c_flush, c_wr_ready;
  logic [18:0]  c_base;
  logic [31:0]  c_in_data;
  logic         c_in_ready, c_wr_en, c_done;
  logic [18:0]  c_wr_addr;
  logic [127:0] c_wr_data;
  logic [19:0]  c_line_cnt;

  logic [18:0] exp_addr [4];

  sram_pack_writer u_a (
    .CLK(clk), .RSTn(rst_n), .enable(a_enable), .base_addr(a_base),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready), .flush(a_flush),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_ready(a_wr_ready),
    .line_cnt(a_line_cnt), .done(a_done)
  );

  sram_pack_writer #(.DEPTH(4)) u_b (
    .CLK(clk), .RSTn(rst_n), .enable(b_enable), .base_addr(b_base),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready), .flush(b_flush),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
    .line_cnt(b_line_cnt), .done(b_done)
  );

  sram_pack_writer #(.PACK_N(4), .MSB_FIRST(0)) u_c (
    .CLK(clk), .RSTn(rst_n), .enable(c_enable), .base_addr(c_base),
    .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready), .flush(c_flush),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .wr_ready(c_wr_ready),
    .line_cnt(c_line_cnt), .done(c_done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic a_word(input logic [31:0] d);
    a_in_valid = 1'b1;
    a_in_data  = d;
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic c_word(input logic [31:0] d);
    c_in_valid = 1'b1;
    c_in_data  = d;
    step();
    c_in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_addr = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};
    rst_n = 1'b0;
    {a_enable, a_in_valid, a_flush, a_wr_ready, a_base, a_in_data} = '0;
    {b_enable, b_in_valid, b_flush, b_wr_ready, b_base, b_in_data} = '0;
    {c_enable, c_in_valid, c_flush, c_wr_ready, c_base, c_in_data} = '0;
    step();
    step();
    check("rst_in_ready", a_in_ready, 0);
    check("rst_wr_en",    a_wr_en,    0);
    check("rst_wr_data",  a_wr_data,  0);
    check("rst_line_cnt", a_line_cnt, 0);
    check("rst_done",     a_done,     0);
    rst_n = 1'b1;
    step();

    // T1: six words back-to-back, two full lines
    a_enable = 1'b1; a_base = 19'h10; a_wr_ready = 1'b1;
    step();
    check("t1_in_ready",  a_in_ready, 1);
    check("t1_addr0",     a_wr_addr,  19'h10);
    a_word(32'd1);
    a_word(32'd2);
    check("t1_no_early_wr", a_wr_en, 0);
    a_word(32'd3);
    check("t1_wr_en1",    a_wr_en,    1);
    check("t1_in_ready_w", a_in_ready, 0);
    check("t1_data1",     a_wr_data,  96'h00000001_00000002_00000003);
    check("t1_addr1",     a_wr_addr,  19'h10);
    step();
    check("t1_wr_en_off", a_wr_en,    0);
    check("t1_cnt1",      a_line_cnt, 1);
    a_word(32'd4);
    a_word(32'd5);
    a_word(32'd6);
    check("t1_data2",     a_wr_data,  96'h00000004_00000005_00000006);
    check("t1_addr2",     a_wr_addr,  19'h11);
    step();
    check("t1_cnt2",      a_line_cnt, 2);

    // Flush with an empty line does nothing
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    check("fl0_no_wr",    a_wr_en,    0);
    check("fl0_in_ready", a_in_ready, 1);

    // T2 + T3: partial line flushed, then held off by wr_ready for 5 cycles
    a_word(32'hAAAA0001);
    a_word(32'hBBBB0002);
    a_wr_ready = 1'b0;
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    a_in_valid = 1'b1;
    a_in_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      check("t3_wr_en",    a_wr_en,    1);
      check("t3_in_ready", a_in_ready, 0);
      check("t3_addr",     a_wr_addr,  19'h12);
      check("t3_data",     a_wr_data,  96'hAAAA0001_BBBB0002_00000000);
      step();
    end
    a_in_valid = 1'b0;
    a_wr_ready = 1'b1;
    step();
    check("t2_cnt",   a_line_cnt, 3);
    check("t2_addr",  a_wr_addr,  19'h13);
    check("t2_clear", a_wr_data,  0);
    a_word(32'd7);
    a_word(32'd8);
    a_word(32'd9);
    check("t2_next_line", a_wr_data, 96'h00000007_00000008_00000009);
    check("t2_next_addr", a_wr_addr, 19'h13);
    step();

    // Flush in the same cycle as an accept
    a_word(32'h11);
    a_flush = 1'b1;
    a_word(32'h22);
    a_flush = 1'b0;
    check("fla_wr_en", a_wr_en,   1);
    check("fla_data",  a_wr_data, 96'h00000011_00000022_00000000);
    check("fla_addr",  a_wr_addr, 19'h14);
    step();
    check("fla_cnt",   a_line_cnt, 5);

    // T5: enable dropped mid-line, then while in WRITE
    a_word(32'h55);
    a_enable = 1'b0;
    step();
    check("t5a_in_ready", a_in_ready, 0);
    check("t5a_cnt",      a_line_cnt, 0);
    check("t5a_data",     a_wr_data,  0);
    a_enable = 1'b1; a_base = 19'h40;
    step();
    check("t5a_addr",     a_wr_addr,  19'h40);
    a_wr_ready = 1'b0;
    a_word(32'hA1);
    a_word(32'hA2);
    a_word(32'hA3);
    check("t5b_wr_en",    a_wr_en,    1);
    a_enable = 1'b0;
    step();
    check("t5b_drop",     a_wr_en,    0);
    check("t5b_cnt",      a_line_cnt, 0);
    a_enable = 1'b1; a_wr_ready = 1'b1;
    step();
    a_word(32'hC1);
    a_word(32'hC2);
    a_word(32'hC3);
    check("t5c_data", a_wr_data, 96'h000000C1_000000C2_000000C3);
    check("t5c_addr", a_wr_addr, 19'h40);
    step();
    check("t5c_cnt",  a_line_cnt, 1);

    // T4: DEPTH=4 with address wrap, then done
    b_enable = 1'b1; b_base = 19'h7FFFE; b_wr_ready = 1'b1;
    step();
    for (int l = 0; l < 4; l++) begin
      for (int w = 0; w < 3; w++) begin
        b_in_valid = 1'b1;
        b_in_data  = 32'(l * 3 + w);
        step();
      end
      b_in_valid = 1'b0;
      check("t4_wr_en", b_wr_en,   1);
      check("t4_addr",  b_wr_addr, exp_addr[l]);
      check("t4_done_early", b_done, 0);
      step();
    end
    check("t4_done",     b_done,     1);
    check("t4_cnt",      b_line_cnt, 4);
    check("t4_in_ready", b_in_ready, 0);
    b_in_valid = 1'b1;
    step();
    step();
    b_in_valid = 1'b0;
    check("t4_hold_done",  b_done,     1);
    check("t4_hold_wr",    b_wr_en,    0);
    check("t4_hold_cnt",   b_line_cnt, 4);
    check("t4_refuse",     b_in_ready, 0);
    b_enable = 1'b0;
    step();
    check("t4_done_clr",   b_done,     0);

    // T6: LSB-first packing of four words, then async reset mid-fill
    c_enable = 1'b1; c_base = 19'h5; c_wr_ready = 1'b1;
    step();
    c_word(32'd1);
    c_word(32'd2);
    c_word(32'd3);
    c_word(32'd4);
    check("t6_wr_en", c_wr_en,   1);
    check("t6_data",  c_wr_data, 128'h00000004_00000003_00000002_00000001);
    check("t6_addr",  c_wr_addr, 19'h5);
    step();
    c_word(32'd5);
    c_word(32'd6);
    check("t6_partial", c_wr_data, 128'h00000000_00000000_00000006_00000005);
    rst_n = 1'b0;
    #1;
    check("t6_rst_in_ready", c_in_ready, 0);
    check("t6_rst_data",     c_wr_data,  0);
    check("t6_rst_cnt",      c_line_cnt, 0);
    check("t6_rst_addr",     c_wr_addr,  0);
    check("t6_rst_wr_en",    c_wr_en,    0);
    step();
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
